// File: rtl/lsu_ram_master.sv
// RV32 load/store initiator for a byte-lane data RAM with a 1-cycle registered read port.
// Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two word cycles.
module lsu_ram_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic [3:0]        wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    output logic [2:0]        dbg_state_o
);

    // Handshake: a request transfers on a rising edge where req_i && ready_o; ready_o is high
    // only in IDLE. rsp_valid_o is a single-cycle pulse with no back-pressure.
`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        ACC_HI = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC    = 3'd1,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_t;
`endif

    state_t state_q, state_d;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              accept;
    logic [1:0]        off_in;
    logic [3:0]        mask_in;
    logic [ADDR_W-1:0] word_addr_in;
    logic              illegal_f3;
    logic              misaligned;
    logic              bad_req;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]        strobe_in;
    logic [63:0]       data_in;
    logic              split_in;
    logic [7:0]        strobe_q;
    logic [31:0]       data_hi_q;
    logic [ADDR_W-1:0] addr_hi_q;
    logic              split_q;
    logic [31:0]       buf_q;
    logic [63:0]       rd_dword;
`else
    logic [3:0]        strobe_in;
    logic [31:0]       data_in;
    logic [3:0]        strobe_q;
`endif

    logic [31:0]       rd_shifted;
    logic [31:0]       load_data;

    // Request decode, evaluated against the live inputs in IDLE.
    always_comb begin
        accept       = req_i && (state_q == IDLE);
        off_in       = addr_i[1:0];
        word_addr_in = {addr_i[ADDR_W-1:2], 2'b00};
        case (funct3_i[1:0])
            2'b00:   mask_in = 4'b0001;
            2'b01:   mask_in = 4'b0011;
            default: mask_in = 4'b1111;
        endcase
        illegal_f3 = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);
        misaligned = ((funct3_i[1:0] == 2'b01) && off_in[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (off_in != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
        strobe_in = {4'b0000, mask_in} << off_in;
        data_in   = {32'h0, wdata_i} << {off_in, 3'b000};
        split_in  = |strobe_in[7:4];
        bad_req   = illegal_f3;
`else
        strobe_in = mask_in << off_in;
        data_in   = wdata_i << {off_in, 3'b000};
        bad_req   = illegal_f3 || misaligned;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bad_req ? ERR : ACC;
                end
            end
            ACC: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_d = ACC_HI;
                end else begin
                    state_d = we_q ? IDLE : RESP;
                end
`else
                state_d = we_q ? IDLE : RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC_HI:  state_d = we_q ? IDLE : RESP;
`endif
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request registers and the RAM address/data registers, which only move when used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            strobe_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            data_hi_q <= '0;
            addr_hi_q <= '0;
            split_q   <= 1'b0;
            buf_q     <= '0;
`endif
        end else begin
            if (accept) begin
                we_q     <= we_i;
                funct3_q <= funct3_i;
                off_q    <= off_in;
                strobe_q <= strobe_in;
`ifdef LSU_MISALIGN_SPLIT_EN
                data_hi_q <= data_in[63:32];
                addr_hi_q <= word_addr_in + ADDR_W'(4);
                split_q   <= split_in && !bad_req;
`endif
                if (!bad_req) begin
                    if (we_i) begin
                        wr_addr_q <= word_addr_in;
                        wr_data_q <= data_in[31:0];
                    end else begin
                        rd_addr_q <= word_addr_in;
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == ACC && split_q) begin
                if (we_q) begin
                    wr_addr_q <= addr_hi_q;
                    wr_data_q <= data_hi_q;
                end else begin
                    rd_addr_q <= addr_hi_q;
                end
            end
            // Read data for the low word lands while the high word is being addressed.
            if (state_q == ACC_HI && !we_q) begin
                buf_q <= rd_data_i;
            end
`endif
        end
    end

    // Load formatting: shift the addressed bytes down, then truncate and extend.
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        rd_dword   = split_q ? {rd_data_i, buf_q} : {32'h0, rd_data_i};
        rd_shifted = 32'(rd_dword >> {off_q, 3'b000});
`else
        rd_shifted = rd_data_i >> {off_q, 3'b000};
`endif
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{!funct3_q[2] && rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_data = {{16{!funct3_q[2] && rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_comb begin
        ready_o     = (state_q == IDLE);
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        rsp_data_o  = '0;
        wr_en_o     = 4'b0000;
        rd_en_o     = 1'b0;
        case (state_q)
            ACC: begin
                if (we_q) begin
                    wr_en_o = strobe_q[3:0];
                end else begin
                    rd_en_o = 1'b1;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                rsp_valid_o = we_q && !split_q;
`else
                rsp_valid_o = we_q;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC_HI: begin
                if (we_q) begin
                    wr_en_o     = strobe_q[7:4];
                    rsp_valid_o = 1'b1;
                end else begin
                    rd_en_o = 1'b1;
                end
            end
`endif
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = load_data;
            end
            ERR: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign rd_addr_o   = rd_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Bench for lsu_ram_master: byte-level reference memory, response scoreboard, directed and random ops.
module tb_lsu_ram_master;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_i = 1'b0;
    logic              ready_o;
    logic              we_i = 1'b0;
    logic [2:0]        funct3_i = 3'b000;
    logic [ADDR_W-1:0] addr_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              rsp_valid_o;
    logic [31:0]       rsp_data_o;
    logic              rsp_err_o;
    logic [3:0]        wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [31:0]       rd_data_i = '0;
    logic [2:0]        dbg_state_o;

    int compared = 0;
    int mismatched = 0;
    logic [32:0] exp_q[$];
    logic [31:0] ram [0:1023];
    logic [7:0]  ref_b [0:4095];

    lsu_ram_master #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // RAM peripheral model: byte-lane writes, one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_o[i]) ram[wr_addr_o[11:2]][8*i +: 8] <= wr_data_o[8*i +: 8];
        end
        if (rd_en_o) rd_data_i <= ram[rd_addr_o[11:2]];
    end

    // Scoreboard and idle-quietness monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            compared++;
            if (ready_o && (rsp_valid_o || wr_en_o != 4'b0 || rd_en_o)) begin
                mismatched++;
                $display("FAIL idle_quiet: rsp_valid=%0b wr_en=%b rd_en=%0b, required all 0", rsp_valid_o, wr_en_o, rd_en_o);
            end
            if (rsp_valid_o) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL rsp_unexpected: err=%0b data=%h, no response expected", rsp_err_o, rsp_data_o);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({rsp_err_o, rsp_data_o} !== e) begin
                        mismatched++;
                        $display("FAIL rsp_scoreboard: err=%0b data=%h, required err=%0b data=%h", rsp_err_o, rsp_data_o, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // Reference model: pushes the expected response and updates the byte memory.
    task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int nb;
        logic bad;
        logic [31:0] v;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
`ifndef LSU_MISALIGN_SPLIT_EN
        if ((addr % nb) != 0) bad = 1'b1;
`endif
        if (bad) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_b[(addr + i) & 32'hFFF] = wd[8*i +: 8];
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[(addr + i) & 32'hFFF];
            if (!f3[2] && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
            if (!f3[2] && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
            exp_q.push_back({1'b0, v});
        end
    endtask

    // Drives one request; returns 1 time unit after the accepting edge.
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, n);
        end
        model_push(we, f3, addr, wd);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(posedge clk);
        #1 req_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if (ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_data_o !== 32'h0 ||
            wr_en_o !== 4'h0 || rd_en_o !== 1'b0 || wr_addr_o !== 32'h0 || rd_addr_o !== 32'h0 || wr_data_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: ready=%0b vld=%0b err=%0b data=%h wen=%b ren=%0b wa=%h ra=%h wd=%h, required ready=1 rest 0",
                     ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, wr_en_o, rd_en_o, wr_addr_o, rd_addr_o, wr_data_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        compared++;
        if (wr_en_o !== 4'b1111 || wr_addr_o !== 32'h100 || wr_data_o !== 32'hDEADBEEF || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rd_en_o !== 1'b0) begin
            mismatched++;
            $display("FAIL sw_port: wen=%b wa=%h wd=%h vld=%0b err=%0b ren=%0b, required 1111 100 deadbeef 1 0 0",
                     wr_en_o, wr_addr_o, wr_data_o, rsp_valid_o, rsp_err_o, rd_en_o);
        end
    endtask

    task automatic test_byte();
        op(1'b1, 3'b000, 32'h103, 32'h000000A5);
        @(negedge clk);
        compared++;
        if (wr_en_o !== 4'b1000 || wr_data_o[31:24] !== 8'hA5 || wr_addr_o !== 32'h100) begin
            mismatched++;
            $display("FAIL sb_port: wen=%b wd=%h wa=%h, required 1000 a5xxxxxx 100", wr_en_o, wr_data_o, wr_addr_o);
        end
        op(1'b0, 3'b000, 32'h103, 32'h0);
        @(negedge clk);
        compared++;
        if (rd_en_o !== 1'b1 || rd_addr_o !== 32'h100 || wr_en_o !== 4'h0 || rsp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL lb_acc: ren=%0b ra=%h wen=%b vld=%0b, required 1 100 0000 0", rd_en_o, rd_addr_o, wr_en_o, rsp_valid_o);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hFFFFFFA5) begin
            mismatched++;
            $display("FAIL lb_data: vld=%0b data=%h, required 1 ffffffa5", rsp_valid_o, rsp_data_o);
        end
        op(1'b0, 3'b100, 32'h103, 32'h0);
        repeat (2) @(negedge clk);
        compared++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h000000A5) begin
            mismatched++;
            $display("FAIL lbu_data: vld=%0b data=%h, required 1 000000a5", rsp_valid_o, rsp_data_o);
        end
    endtask

    task automatic test_half();
        op(1'b1, 3'b010, 32'h100, 32'h80017F00);
        op(1'b0, 3'b001, 32'h102, 32'h0);
        @(negedge clk);
        compared++;
        if (rd_addr_o !== 32'h100 || rd_en_o !== 1'b1) begin
            mismatched++;
            $display("FAIL lh_addr: ra=%h ren=%0b, required 100 1", rd_addr_o, rd_en_o);
        end
        @(negedge clk);
        compared++;
        if (rsp_data_o !== 32'hFFFF8001 || rsp_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL lh_data: data=%h vld=%0b, required ffff8001 1", rsp_data_o, rsp_valid_o);
        end
        op(1'b0, 3'b101, 32'h102, 32'h0);
        repeat (2) @(negedge clk);
        compared++;
        if (rsp_data_o !== 32'h00008001 || rsp_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL lhu_data: data=%h vld=%0b, required 00008001 1", rsp_data_o, rsp_valid_o);
        end
    endtask

    task automatic check_err(input string name);
        @(negedge clk);
        compared++;
        if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0 || rd_en_o !== 1'b0 || wr_en_o !== 4'h0) begin
            mismatched++;
            $display("FAIL %s: vld=%0b err=%0b data=%h ren=%0b wen=%b, required 1 1 0 0 0", name, rsp_valid_o, rsp_err_o, rsp_data_o, rd_en_o, wr_en_o);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid_o !== 1'b0 || ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_end: vld=%0b ready=%0b, required 0 1", name, rsp_valid_o, ready_o);
        end
    endtask

    task automatic test_errors();
        op(1'b0, 3'b011, 32'h100, 32'h0);
        check_err("err_f3_011");
        op(1'b1, 3'b100, 32'h104, 32'h55);
        check_err("err_store_f3");
        op(1'b0, 3'b110, 32'h100, 32'h0);
        check_err("err_f3_110");
`ifndef LSU_MISALIGN_SPLIT_EN
        op(1'b0, 3'b010, 32'h101, 32'h0);
        check_err("err_lw_misalign");
        op(1'b1, 3'b001, 32'h103, 32'h1234);
        check_err("err_sh_misalign");
`endif
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_split();
        op(1'b1, 3'b010, 32'h0FE, 32'h11223344);
        @(negedge clk);
        compared++;
        if (wr_en_o !== 4'b1100 || wr_addr_o !== 32'h0FC || wr_data_o[31:16] !== 16'h3344 || rsp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL split_sw_lo: wen=%b wa=%h wd=%h vld=%0b, required 1100 0fc 3344xxxx 0", wr_en_o, wr_addr_o, wr_data_o, rsp_valid_o);
        end
        @(negedge clk);
        compared++;
        if (wr_en_o !== 4'b0011 || wr_addr_o !== 32'h100 || wr_data_o[15:0] !== 16'h1122 || rsp_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL split_sw_hi: wen=%b wa=%h wd=%h vld=%0b, required 0011 100 xxxx1122 1", wr_en_o, wr_addr_o, wr_data_o, rsp_valid_o);
        end
        op(1'b0, 3'b010, 32'h0FE, 32'h0);
        @(negedge clk);
        compared++;
        if (rd_en_o !== 1'b1 || rd_addr_o !== 32'h0FC) begin
            mismatched++;
            $display("FAIL split_lw_lo: ren=%0b ra=%h, required 1 0fc", rd_en_o, rd_addr_o);
        end
        @(negedge clk);
        compared++;
        if (rd_en_o !== 1'b1 || rd_addr_o !== 32'h100 || rsp_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL split_lw_hi: ren=%0b ra=%h vld=%0b, required 1 100 0", rd_en_o, rd_addr_o, rsp_valid_o);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h11223344) begin
            mismatched++;
            $display("FAIL split_lw_data: vld=%0b data=%h, required 1 11223344", rsp_valid_o, rsp_data_o);
        end
    endtask
`endif

    task automatic test_reset_mid();
        op(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
        op(1'b0, 3'b010, 32'h200, 32'h0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        compared++;
        if (ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rd_en_o !== 1'b0 || rsp_data_o !== 32'h0 || rd_addr_o !== 32'h0 || wr_addr_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_mid: ready=%0b vld=%0b ren=%0b data=%h ra=%h wa=%h, required 1 0 0 0 0 0",
                     ready_o, rsp_valid_o, rd_en_o, rsp_data_o, rd_addr_o, wr_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b1, 3'b010, 32'h204, 32'h12345678);
        @(negedge clk);
        compared++;
        if (wr_en_o !== 4'b1111 || wr_addr_o !== 32'h204 || wr_data_o !== 32'h12345678 || rsp_valid_o !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset_sw: wen=%b wa=%h wd=%h vld=%0b, required 1111 204 12345678 1", wr_en_o, wr_addr_o, wr_data_o, rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s [0:4];
        logic [2:0] f3;
        logic we;
        logic [31:0] addr;
        int nb;
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
        for (int k = 0; k < 60; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
            nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            addr = 32'h300 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
            op(we, f3, addr, $urandom);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'h0;
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_errors();
`ifdef LSU_MISALIGN_SPLIT_EN
        test_split();
`endif
        test_reset_mid();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL rsp_missing: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Load/store initiator that drives the byte-lane data RAM peripheral: 4-bit byte write enables, separate write/read address ports, 1-cycle registered read data.
- Sits between the core's memory-access stage and the RAM.
- Converts RV32 load/store requests (funct3, address, store data) into RAM port cycles.
- Returns sign/zero-extended load data plus a completion/error response.

Parameters:
- ADDR_W, 32, width of the core address and the RAM address ports. Data width is fixed at 32.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  request valid; accepted when req_i && ready_o
- ready_o  out  1  high only in IDLE
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle completion pulse; no back-pressure
- rsp_data_o  out  32  formatted load data; 0 for stores and errors
- rsp_err_o  out  1  valid with rsp_valid_o; illegal funct3 or unsupported misalignment
- wr_en_o  out  4  RAM byte write enables, bit n = byte lane n
- wr_addr_o  out  ADDR_W  RAM write address, word aligned ([1:0]=0)
- wr_data_o  out  32  RAM write data, lane-shifted
- rd_en_o  out  1  RAM read enable
- rd_addr_o  out  ADDR_W  RAM read address, word aligned
- rd_data_i  in  32  RAM read data, valid the cycle after rd_en_o/rd_addr_o

Behaviour:
- Reset (async, any state): state=IDLE; every output 0 except ready_o=1; internal request and buffer registers cleared. A request in flight at reset is dropped with no response.
- Accept edge:
  - Latch we, funct3, off=addr_i[1:0], word address A=addr_i & ~3.
  - Size mask m: byte=0x1, half=0x3, word=0xF.
  - 8-bit strobe S = m<<off; 64-bit shifted data D = wdata_i<<(8*off).
- Error checks: illegal funct3 (011, 11x, or store with funct3[2]=1), or misalignment (LH/LHU/SH with off odd, LW/SW with off≠0).
  - Either condition: go to ERR; no RAM port activity.
  - ERR lasts one cycle: rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0; then IDLE.
- Aligned store: ACC (1 cycle) drives wr_en_o=S[3:0], wr_addr_o=A, wr_data_o=D[31:0]; rsp_valid_o=1 in the same cycle; then IDLE. Latency accept→rsp 1 cycle; throughput 1 store per 2 cycles.
- Aligned load:
  - ACC drives rd_en_o=1, rd_addr_o=A.
  - RESP: rd_data_i valid; rsp_data_o = (rd_data_i>>(8*off)) truncated to size, sign-extended (LB/LH) or zero-extended (LBU/LHU); rsp_valid_o=1.
  - Then IDLE. Latency 2 cycles; 1 load per 3 cycles.
- States: IDLE, ACC, ACC_HI (feature only), RESP, ERR.
- wr_en_o, rd_en_o and rsp_valid_o are never asserted in IDLE.
- wr_en_o is 0 on loads; rd_en_o is 0 on stores.
- Address and data outputs hold their last values when enables are low.
- req_i is ignored while ready_o=0.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned LH/LHU/SH/LW/SW are legal.
  - If S[7:4]==0, the access is a single ACC as above.
  - Otherwise it splits into two word accesses:
    - ACC: word A with lanes S[3:0] / D[31:0].
    - ACC_HI: word A+4 with lanes S[7:4] / D[63:32]; A+4 wraps modulo 2^ADDR_W.
  - Store: rsp_valid_o pulses in ACC_HI; latency 2.
  - Load:
    - In ACC_HI, rd_data_i (low word) is captured into a 32-bit buffer.
    - In RESP, ({rd_data_i, buffer}>>(8*off)) is formatted; latency 3.
  - Illegal funct3 still goes to ERR.
- Undefined: no ACC_HI state and no buffer; all misalignment goes to ERR.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF → next cycle wr_en_o=1111, wr_addr_o=0x100, wr_data_o=0xDEADBEEF, rsp_valid_o=1, err=0.
- SB addr 0x103, data 0x000000A5 → wr_en_o=1000, wr_data_o[31:24]=0xA5. Then LB 0x103 → rsp_data_o=0xFFFFFFA5 two cycles after accept; LBU 0x103 → 0x000000A5.
- LH 0x102, word 0x80017F00 stored → 0xFFFF8001; LHU → 0x00008001; rd_addr_o=0x100.
- LW 0x101 without feature → ERR pulse: rsp_err_o=1, rsp_data_o=0, rd_en_o and wr_en_o never high. funct3=011 → same.
- With LSU_MISALIGN_SPLIT_EN: SW 0x0FE, data 0x11223344 → cycle1 wr_en_o=1100 @0x0FC (data[31:16]=0x3344); cycle2 wr_en_o=0011 @0x100 (data[15:0]=0x1122). LW 0x0FE → 0x11223344 at cycle 3.
- Assert rst_n=0 during RESP of a load → outputs 0 and ready_o=1 immediately with no rsp_valid_o; the next SW after reset completes normally.
